// File: rtl/dragonfang_floating_point_pkg.sv
// Shared types and constants for the vector FP sign-injection datapath.
package dragonfang_floating_point_pkg;

  typedef enum logic [1:0] {
    SGNJ      = 2'b00,
    SGNJN     = 2'b01,
    SGNJX     = 2'b10,
    SGNJ_RSVD = 2'b11
  } sgnj_funct_e;

  typedef enum logic [1:0] {
    SEW_RSVD = 2'b00,
    SEW_E16  = 2'b01,
    SEW_E32  = 2'b10,
    SEW_E64  = 2'b11
  } sew_e;

  localparam logic [15:0] CANON_NAN_E16 = 16'h7E00;
  localparam logic [31:0] CANON_NAN_E32 = 32'h7FC0_0000;

  // Operation control; the VLEN-dependent operand fields are added by the pipeline top.
  typedef struct packed {
    sgnj_funct_e funct;
    logic        is_vf;
    sew_e        sew;
    logic        vm;
  } sgnj_ctrl_t;

  function automatic logic inject_sign(input sgnj_funct_e f, input logic s1, input logic s2);
    case (f)
      SGNJ:    return s1;
      SGNJN:   return ~s1;
      default: return s1 ^ s2;
    endcase
  endfunction

endpackage

// File: rtl/vector_floating_point_sign_injection_lane.sv
// Combinational sign injection for one VLEN word: per-SEW element split, vl/v0 masking,
// tail-undisturbed merge with vd_old and NaN-boxing of the scalar sign source.
module vector_floating_point_sign_injection_lane
  import dragonfang_floating_point_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned FLEN = 64,
  localparam int unsigned VL_W = $clog2(VLEN / 16) + 1,
  localparam int unsigned MASK_W = VLEN / 16
) (
  input  sgnj_ctrl_t          ctrl,
  input  logic [VL_W-1:0]     vl,
  input  logic [MASK_W-1:0]   v0_mask,
  input  logic [VLEN-1:0]     vs2,
  input  logic [VLEN-1:0]     vs1,
  input  logic [FLEN-1:0]     rs1,
  input  logic [VLEN-1:0]     vd_old,
  output logic [VLEN-1:0]     vd
);

  logic boxed16, boxed32;
  logic sign16, sign32, sign64;
  logic unused_vs1;

  // Scalar is properly boxed when every bit above the element width is one.
  assign boxed16 = &(rs1 | FLEN'(16'hFFFF));
  assign boxed32 = &(rs1 | FLEN'(32'hFFFF_FFFF));
  assign sign16  = boxed16 ? rs1[15] : CANON_NAN_E16[15];
  assign sign32  = boxed32 ? rs1[31] : CANON_NAN_E32[31];
  assign sign64  = rs1[FLEN-1];

  // Only the sign bits of vs1 matter.
  assign unused_vs1 = ^vs1;

  always_comb begin
    vd = vd_old;
    if (ctrl.funct != SGNJ_RSVD) begin
      case (ctrl.sew)
        SEW_E16: begin
          for (int i = 0; i < int'(VLEN / 16); i++) begin
            if ((VL_W'(i) < vl) && (ctrl.vm || v0_mask[i])) begin
              vd[i*16 +: 16] = {inject_sign(ctrl.funct, ctrl.is_vf ? sign16 : vs1[i*16+15],
                                            vs2[i*16+15]), vs2[i*16 +: 15]};
            end
          end
        end
        SEW_E32: begin
          for (int i = 0; i < int'(VLEN / 32); i++) begin
            if ((VL_W'(i) < vl) && (ctrl.vm || v0_mask[i])) begin
              vd[i*32 +: 32] = {inject_sign(ctrl.funct, ctrl.is_vf ? sign32 : vs1[i*32+31],
                                            vs2[i*32+31]), vs2[i*32 +: 31]};
            end
          end
        end
        SEW_E64: begin
          for (int i = 0; i < int'(VLEN / 64); i++) begin
            if ((VL_W'(i) < vl) && (ctrl.vm || v0_mask[i])) begin
              vd[i*64 +: 64] = {inject_sign(ctrl.funct, ctrl.is_vf ? sign64 : vs1[i*64+63],
                                            vs2[i*64+63]), vs2[i*64 +: 63]};
            end
          end
        end
        default: vd = vd_old;
      endcase
    end
  end

endmodule

// File: rtl/vector_floating_point_sign_injection_pipeline.sv
// Pipelined vector FP sign injection with valid/ready handshake and NUM_STAGES registers.
// Optional perf counters: define DRAGONFANG_SGNJ_PERF_COUNTERS_EN.
module vector_floating_point_sign_injection_pipeline
  import dragonfang_floating_point_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned FLEN = 64,
  localparam int unsigned VL_W = $clog2(VLEN / 16) + 1,
  localparam int unsigned MASK_W = VLEN / 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        funct,
  input  logic              is_vf,
  input  logic [1:0]        sew,
  input  logic [VL_W-1:0]   vl,
  input  logic              vm,
  input  logic [MASK_W-1:0] v0_mask,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vs1,
  input  logic [FLEN-1:0]   rs1,
  input  logic [VLEN-1:0]   vd_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   vd
`ifdef DRAGONFANG_SGNJ_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall_cycles
`endif
);

  // Result registers after the compute point; one request register precedes them when NUM_STAGES > 1.
  localparam int unsigned RES_STAGES = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  typedef struct packed {
    sgnj_ctrl_t        ctrl;
    logic [VL_W-1:0]   vl;
    logic [MASK_W-1:0] v0_mask;
    logic [VLEN-1:0]   vs2;
    logic [VLEN-1:0]   vs1;
    logic [FLEN-1:0]   rs1;
    logic [VLEN-1:0]   vd_old;
  } sgnj_request_t;

  sgnj_request_t                   req_in, lane_req;
  logic                            lane_v, stall;
  logic [VLEN-1:0]                 lane_vd;
  logic [RES_STAGES-1:0]           res_v;
  logic [RES_STAGES-1:0][VLEN-1:0] res_d;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    req_in.ctrl.funct = sgnj_funct_e'(funct);
    req_in.ctrl.is_vf = is_vf;
    req_in.ctrl.sew   = sew_e'(sew);
    req_in.ctrl.vm    = vm;
    req_in.vl         = vl;
    req_in.v0_mask    = v0_mask;
    req_in.vs2        = vs2;
    req_in.vs1        = vs1;
    req_in.rs1        = rs1;
    req_in.vd_old     = vd_old;
  end

  generate
    if (NUM_STAGES == 1) begin : g_no_req_reg
      assign lane_req = req_in;
      assign lane_v   = in_valid;
    end else begin : g_req_reg
      sgnj_request_t req_q;
      logic          req_v;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          req_q <= '0;
          req_v <= 1'b0;
        end else if (!stall) begin
          req_q <= req_in;
          req_v <= in_valid;
        end
      end

      assign lane_req = req_q;
      assign lane_v   = req_v;
    end
  endgenerate

  vector_floating_point_sign_injection_lane #(
    .VLEN (VLEN),
    .FLEN (FLEN)
  ) u_lane (
    .ctrl    (lane_req.ctrl),
    .vl      (lane_req.vl),
    .v0_mask (lane_req.v0_mask),
    .vs2     (lane_req.vs2),
    .vs1     (lane_req.vs1),
    .rs1     (lane_req.rs1),
    .vd_old  (lane_req.vd_old),
    .vd      (lane_vd)
  );

  // Whole pipe advances together; bubbles move with the ops rather than being squeezed out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_v <= '0;
      res_d <= '0;
    end else if (!stall) begin
      res_v[0] <= lane_v;
      res_d[0] <= lane_vd;
      for (int s = 1; s < int'(RES_STAGES); s++) begin
        res_v[s] <= res_v[s-1];
        res_d[s] <= res_d[s-1];
      end
    end
  end

  assign out_valid = res_v[RES_STAGES-1];
  assign vd        = res_d[RES_STAGES-1];

`ifdef DRAGONFANG_SGNJ_PERF_COUNTERS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_ops          <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_floating_point_sign_injection_pipeline.sv
// Self-checking bench for the sign-injection pipeline: directed cases plus a randomized stream
// scored against an element-wise reference model.
module tb_vector_floating_point_sign_injection_pipeline;

  localparam int unsigned VLEN = 128;
  localparam int unsigned NUM_STAGES = 2;
  localparam int unsigned FLEN = 64;
  localparam int unsigned VL_W = $clog2(VLEN / 16) + 1;
  localparam int unsigned MW = VLEN / 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [1:0]      funct, sew;
  logic            is_vf, vm;
  logic [VL_W-1:0] vl;
  logic [MW-1:0]   v0_mask;
  logic [VLEN-1:0] vs2, vs1, vd_old, vd;
  logic [FLEN-1:0] rs1;
  logic            out_valid, out_ready;
`ifdef DRAGONFANG_SGNJ_PERF_COUNTERS_EN
  logic [31:0]     perf_ops, perf_stall_cycles;
`endif

  vector_floating_point_sign_injection_pipeline #(
    .VLEN(VLEN), .NUM_STAGES(NUM_STAGES), .FLEN(FLEN)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .is_vf(is_vf), .sew(sew), .vl(vl), .vm(vm), .v0_mask(v0_mask),
    .vs2(vs2), .vs1(vs1), .rs1(rs1), .vd_old(vd_old),
    .out_valid(out_valid), .out_ready(out_ready), .vd(vd)
`ifdef DRAGONFANG_SGNJ_PERF_COUNTERS_EN
    , .perf_ops(perf_ops), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0]      o_funct, o_sew;
  logic            o_vf, o_vm;
  logic [VL_W-1:0] o_vl;
  logic [MW-1:0]   o_mask;
  logic [VLEN-1:0] o_vs2, o_vs1, o_old;
  logic [FLEN-1:0] o_rs1;

  logic [VLEN-1:0] exp_q[$];
  bit              was_stall;
  logic [VLEN-1:0] held_vd;

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk elements arithmetically from the ISA rules.
  function automatic logic [VLEN-1:0] model();
    logic [VLEN-1:0] res, low, e;
    int sewb, n, vle;
    logic boxed, sc_sign, s1, s2, sg;
    res = o_old;
    if (o_funct == 2'd3 || o_sew == 2'd0) return res;
    sewb = 8 << o_sew;
    n = VLEN / sewb;
    vle = (int'(o_vl) < n) ? int'(o_vl) : n;
    if (sewb < FLEN) boxed = ((o_rs1 >> sewb) == ({FLEN{1'b1}} >> sewb));
    else boxed = 1'b1;
    sc_sign = boxed ? o_rs1[sewb-1] : 1'b0;  // canonical NaN is positive
    low = {VLEN{1'b1}} >> (VLEN - sewb);
    for (int i = 0; i < vle; i++) begin
      if (o_vm || o_mask[i]) begin
        e  = (o_vs2 >> (i * sewb)) & low;
        s2 = e[sewb-1];
        s1 = o_vf ? sc_sign : o_vs1[i*sewb + sewb - 1];
        case (o_funct)
          2'd0:    sg = s1;
          2'd1:    sg = !s1;
          default: sg = s1 ^ s2;
        endcase
        e   = (e & (low >> 1)) | (VLEN'(sg) << (sewb - 1));
        res = (res & ~(low << (i * sewb))) | (e << (i * sewb));
      end
    end
    return res;
  endfunction

  task automatic rand_op();
    o_funct = 2'($urandom_range(0, 3));
    o_sew   = 2'($urandom_range(0, 3));
    o_vf    = 1'($urandom_range(0, 1));
    o_vm    = 1'($urandom_range(0, 1));
    o_vl    = VL_W'($urandom_range(0, (1 << VL_W) - 1));
    o_mask  = MW'($urandom);
    o_vs2   = {$urandom, $urandom, $urandom, $urandom};
    o_vs1   = {$urandom, $urandom, $urandom, $urandom};
    o_old   = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 2))
      0:       o_rs1 = {$urandom, $urandom};
      1:       o_rs1 = {48'hFFFF_FFFF_FFFF, 16'($urandom)};
      default: o_rs1 = {32'hFFFF_FFFF, $urandom};
    endcase
  endtask

  task automatic drive();
    funct = o_funct; sew = o_sew; is_vf = o_vf; vm = o_vm; vl = o_vl;
    v0_mask = o_mask; vs2 = o_vs2; vs1 = o_vs1; rs1 = o_rs1; vd_old = o_old;
  endtask

  // One isolated op: checks latency, optional stall hold, result and drain.
  task automatic run_single(input int hold, input logic [VLEN-1:0] exp, input string tag);
    int lat;
    drive();
    in_valid = 1'b1;
    out_ready = (hold == 0);
    #1;
    check({tag, "_in_ready"}, VLEN'(in_ready), VLEN'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, VLEN'(lat), VLEN'(NUM_STAGES));
    if (hold > 0) begin
      held_vd = vd;
      repeat (hold) begin @(posedge clock); #1; end
      check({tag, "_hold_vd"}, vd, held_vd);
      check({tag, "_hold_valid"}, VLEN'(out_valid), VLEN'(1));
      check({tag, "_stall_ready"}, VLEN'(in_ready), VLEN'(0));
      out_ready = 1'b1;
      #1;
    end
    check({tag, "_vd"}, vd, exp);
    @(posedge clock); #1;
    check({tag, "_drained"}, VLEN'(out_valid), VLEN'(0));
  endtask

  // One streaming cycle at posedge+1 with inputs already driven.
  task automatic tick(output bit acc, inout int got);
    check("stream_in_ready", VLEN'(in_ready), VLEN'(!(out_valid && !out_ready)));
    if (was_stall) begin
      check("stream_stall_vd", vd, held_vd);
      check("stream_stall_valid", VLEN'(out_valid), VLEN'(1));
    end
    if (out_valid && out_ready) begin
      check("stream_nonempty", VLEN'(exp_q.size() != 0), VLEN'(1));
      if (exp_q.size() != 0) begin
        check("stream_vd", vd, exp_q.pop_front());
        got++;
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model());
    was_stall = out_valid && !out_ready;
    held_vd = vd;
    @(posedge clock); #1;
  endtask

  initial begin
    bit acc;
    bit pending;
    int got, sent, total;
    logic [3:0] patt;
    logic [VLEN-1:0] ev;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rand_op(); drive();
    #2;
    check("reset_out_valid", VLEN'(out_valid), VLEN'(0));
    check("reset_vd", vd, '0);
    check("reset_in_ready", VLEN'(in_ready), VLEN'(1));
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // e32 .vv sgnjn: +1.0 becomes -1.0
    o_funct = 2'd1; o_vf = 1'b0; o_sew = 2'd2; o_vl = VL_W'(4); o_vm = 1'b1; o_mask = '0;
    o_vs2 = {4{32'h3F80_0000}}; o_vs1 = '0; o_rs1 = '0; o_old = {$urandom, $urandom, $urandom, $urandom};
    run_single(0, {4{32'hBF80_0000}}, "e32_sgnjn");

    // e16 .vf sgnj with an improperly boxed scalar: sign forced to 0
    o_funct = 2'd0; o_vf = 1'b1; o_sew = 2'd1; o_vl = VL_W'(8); o_vm = 1'b1;
    o_rs1 = 64'h0000_0000_0000_BC00; o_vs2 = {$urandom, $urandom, $urandom, $urandom};
    ev = o_vs2 & {8{16'h7FFF}};
    run_single(0, ev, "e16_vf_unboxed");

    // e64 sgnjx with element 0 masked and element 1 tail
    o_funct = 2'd2; o_vf = 1'b0; o_sew = 2'd3; o_vl = VL_W'(1); o_vm = 1'b0; o_mask = '0;
    o_old = {8{16'hAAAA}};
    run_single(0, {8{16'hAAAA}}, "e64_masked_tail");

    // reserved encodings pass vd_old through
    rand_op(); o_funct = 2'd3; o_sew = 2'd2; o_vm = 1'b1; o_vl = VL_W'(4);
    run_single(0, o_old, "rsvd_funct");
    rand_op(); o_funct = 2'd0; o_sew = 2'd0; o_vm = 1'b1; o_vl = VL_W'(8);
    run_single(0, o_old, "rsvd_sew");

    // e32 .vf sgnjx, properly boxed negative scalar, vl beyond element count
    rand_op(); o_funct = 2'd2; o_vf = 1'b1; o_sew = 2'd2; o_vm = 1'b1; o_vl = VL_W'(9);
    o_rs1 = {32'hFFFF_FFFF, 32'h8000_0000};
    ev = o_vs2 ^ {4{32'h8000_0000}};
    run_single(0, ev, "e32_vf_boxed_vlmax");

    // e16 partial vl with v0 mask, checked against the model
    rand_op(); o_sew = 2'd1; o_funct = 2'd1; o_vm = 1'b0; o_vl = VL_W'(5);
    run_single(2, model(), "e16_mask_partial");

    // streaming: 8 ops with out_ready 1,0,0,1... then random backpressure
    patt = 4'b1001;
    pending = 1'b0; got = 0; sent = 0; total = 32; was_stall = 1'b0;
    for (int cyc = 0; cyc < 600 && (sent < total || exp_q.size() != 0); cyc++) begin
      if (!pending && sent < total) begin
        rand_op(); drive(); pending = 1'b1;
      end
      in_valid = pending;
      out_ready = (sent < 8) ? patt[cyc % 4] : 1'($urandom_range(0, 1));
      #1;
      tick(acc, got);
      if (acc) begin pending = 1'b0; sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_all_sent", VLEN'(sent), VLEN'(total));
    check("stream_all_received", VLEN'(got), VLEN'(total));
    check("stream_queue_empty", VLEN'(exp_q.size()), VLEN'(0));

    // reset with two ops in flight
    @(posedge clock); #1;
    rand_op(); drive(); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    rand_op(); drive();
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("inflight_pre_reset_valid", VLEN'(out_valid), VLEN'(1));
    reset = 1'b1;
    #1;
    check("midreset_out_valid", VLEN'(out_valid), VLEN'(0));
    check("midreset_vd", vd, '0);
    check("midreset_in_ready", VLEN'(in_ready), VLEN'(1));
    @(negedge clock); reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check("postreset_no_ghost", VLEN'(out_valid), VLEN'(0));
    end
    rand_op(); o_funct = 2'd0; o_sew = 2'd3; o_vm = 1'b1; o_vl = VL_W'(2);
    run_single(0, model(), "postreset_op");

`ifdef DRAGONFANG_SGNJ_PERF_COUNTERS_EN
    reset = 1'b1; #1;
    check("perf_reset_ops", VLEN'(perf_ops), VLEN'(0));
    check("perf_reset_stall", VLEN'(perf_stall_cycles), VLEN'(0));
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    repeat (4) begin
      rand_op();
      run_single(0, model(), "perf_op");
    end
    rand_op();
    run_single(3, model(), "perf_stall_op");
    check("perf_ops", VLEN'(perf_ops), VLEN'(5));
    check("perf_stall_cycles", VLEN'(perf_stall_cycles), VLEN'(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
